// File: rtl/ddr_init_seq.sv
// LPDDR4 power-up/recovery sequencer: releases PLL, PHY, controller and AXI resets in order and supervises PLL lock.
// Define DDR_INIT_RETRY_EN to allow up to MAX_RETRY automatic re-initialisation attempts before HALT.
module ddr_init_seq #(
  parameter int PLL_RST_CYC      = 100,
  parameter int LOCK_TIMEOUT_CYC = 100000,
  parameter int CFG_TIMEOUT_CYC  = 10000000,
  parameter int RST_GAP_CYC      = 16,
  parameter int MAX_RETRY        = 3
) (
  input  logic       clk_100,
  input  logic       sys_rstn,
  input  logic       start,
  input  logic       ddr_pll_lock,
  input  logic       cfg_done,
  output logic       ddr_pll_rstn,
  output logic       phy_rstn,
  output logic       ctrl_rstn,
  output logic       cfg_sel,
  output logic       cfg_reset,
  output logic       cfg_start,
  output logic       axi_arstn,
  output logic       init_done,
  output logic       init_err,
  output logic [1:0] err_code,
  output logic [1:0] retry_cnt,
  output logic [3:0] state
);

  localparam int MAX_AB  = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CD  = (CFG_TIMEOUT_CYC > RST_GAP_CYC) ? CFG_TIMEOUT_CYC : RST_GAP_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
`ifdef DDR_INIT_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PLL_RST  = 4'd1,
    S_PLL_WAIT = 4'd2,
    S_PHY_REL  = 4'd3,
    S_CTRL_REL = 4'd4,
    S_CFG      = 4'd5,
    S_AXI_REL  = 4'd6,
    S_RUN      = 4'd7,
    S_ERR      = 4'd8,
    S_HALT     = 4'd9
  } state_e;

  logic [1:0]    lock_sync_q;
  logic [1:0]    done_sync_q;
  logic          lock_s;
  logic          done_s;
  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [1:0]    err_q;
  logic [1:0]    err_d;
  logic [1:0]    retry_q;
  logic [1:0]    retry_d;
  logic [8:0]    out_q;
  logic          cnt_zero;
  logic          lock_lost;

  // Counter value loaded on entry so that a state of N cycles leaves when the counter reaches zero.
  function automatic logic [CW-1:0] dwell(input state_e s);
    case (s)
      S_PLL_RST:                      dwell = CW'(PLL_RST_CYC - 1);
      S_PLL_WAIT:                     dwell = CW'(LOCK_TIMEOUT_CYC - 1);
      S_PHY_REL, S_CTRL_REL, S_AXI_REL: dwell = CW'(RST_GAP_CYC - 1);
      S_CFG:                          dwell = CW'(CFG_TIMEOUT_CYC - 1);
      default:                        dwell = {CW{1'b0}};
    endcase
  endfunction

  // Output pattern {pll_rstn, phy_rstn, ctrl_rstn, cfg_sel, cfg_reset, cfg_start, axi_arstn, init_done, init_err}.
  function automatic logic [8:0] out_map(input state_e s);
    case (s)
      S_PLL_RST:  out_map = 9'b000_110_000;
      S_PLL_WAIT: out_map = 9'b100_110_000;
      S_PHY_REL:  out_map = 9'b110_110_000;
      S_CTRL_REL: out_map = 9'b111_110_000;
      S_CFG:      out_map = 9'b111_101_000;
      S_AXI_REL:  out_map = 9'b111_100_000;
      S_RUN:      out_map = 9'b111_100_110;
      S_HALT:     out_map = 9'b000_010_001;
      default:    out_map = 9'b000_010_000;
    endcase
  endfunction

  // Two-flop synchronisers for the asynchronous PLL lock and configuration-done inputs
  always_ff @(posedge clk_100 or negedge sys_rstn) begin
    if (!sys_rstn) begin
      lock_sync_q <= 2'b00;
      done_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], ddr_pll_lock};
      done_sync_q <= {done_sync_q[0], cfg_done};
    end
  end

  assign lock_s    = lock_sync_q[1];
  assign done_s    = done_sync_q[1];
  assign cnt_zero  = (cnt_q == {CW{1'b0}});
  assign lock_lost = !lock_s && (state_q inside {S_PHY_REL, S_CTRL_REL, S_CFG, S_AXI_REL, S_RUN});

  // Next-state, error/retry bookkeeping and shared counter; lock loss outranks events, events outrank timeouts
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_PLL_RST;
      S_PLL_RST: begin
        if (cnt_zero) state_d = S_PLL_WAIT;
        else          state_d = S_PLL_RST;
      end
      S_PLL_WAIT: begin
        if (lock_s) begin
          state_d = S_PHY_REL;
        end else if (cnt_zero) begin
          state_d = S_ERR;
          err_d   = 2'd1;
        end else begin
          state_d = S_PLL_WAIT;
        end
      end
      S_PHY_REL, S_CTRL_REL, S_AXI_REL: begin
        if (lock_lost) begin
          state_d = S_ERR;
          err_d   = 2'd3;
        end else if (cnt_zero) begin
          state_d = state_e'(state_q + 4'd1);
        end else begin
          state_d = state_q;
        end
      end
      S_CFG: begin
        if (lock_lost) begin
          state_d = S_ERR;
          err_d   = 2'd3;
        end else if (done_s) begin
          state_d = S_AXI_REL;
        end else if (cnt_zero) begin
          state_d = S_ERR;
          err_d   = 2'd2;
        end else begin
          state_d = S_CFG;
        end
      end
      S_RUN: begin
        if (lock_lost) begin
          state_d = S_ERR;
          err_d   = 2'd3;
        end else if (start) begin
          state_d = S_PLL_RST;
          err_d   = 2'd0;
          retry_d = 2'd0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_ERR: begin
        if (RETRY_EN && (retry_q < RETRY_LIMIT)) begin
          state_d = S_PLL_RST;
          retry_d = retry_q + 2'd1;
        end else begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_PLL_RST;
          err_d   = 2'd0;
          retry_d = 2'd0;
        end else begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = dwell(state_d);
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counter, status and registered output pattern decoded from the next state
  always_ff @(posedge clk_100 or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      err_q   <= 2'd0;
      retry_q <= 2'd0;
      out_q   <= out_map(S_IDLE);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      out_q   <= out_map(state_d);
    end
  end

  assign ddr_pll_rstn = out_q[8];
  assign phy_rstn     = out_q[7];
  assign ctrl_rstn    = out_q[6];
  assign cfg_sel      = out_q[5];
  assign cfg_reset    = out_q[4];
  assign cfg_start    = out_q[3];
  assign axi_arstn    = out_q[2];
  assign init_done    = out_q[1];
  assign init_err     = out_q[0];
  assign err_code     = err_q;
  assign retry_cnt    = retry_q;
  assign state        = state_q;

endmodule

// File: doc/ddr_init_seq.md
# ddr_init_seq

Power-up and recovery sequencer for the LPDDR4 hard controller, running on `clk_100` beside the USB processing logic.
- Drives the DDR PLL reset, PHY and controller resets, and the cfg_* start handshake in a fixed order.
- Releases the AXI-side reset only after configuration completes, then supervises PLL lock and re-initialises on failure.
- Exports status and debug state for the LEDs and the USB register space.

## Interface
- `PLL_RST_CYC`, default 100: cycles `ddr_pll_rstn` is held low in PLL_RST (≥1).
- `LOCK_TIMEOUT_CYC`, default 100000: cycles allowed for `ddr_pll_lock` in PLL_WAIT.
- `CFG_TIMEOUT_CYC`, default 10000000: cycles allowed for `cfg_done` in CFG.
- `RST_GAP_CYC`, default 16: dwell cycles in PHY_REL, CTRL_REL and AXI_REL (≥1).
- `MAX_RETRY`, default 3: automatic re-init attempts before HALT (≤3).
- `clk_100` in 1: sole clock.
- `sys_rstn` in 1: reset, asynchronous assert, active-low.
- `start` in 1: single-cycle restart request.
- `ddr_pll_lock` in 1: asynchronous; 2-FF synchronised to `lock_s`.
- `cfg_done` in 1: asynchronous; 2-FF synchronised to `done_s`.
- `ddr_pll_rstn` out 1: DDR PLL reset, active-low.
- `phy_rstn` out 1: PHY reset, active-low.
- `ctrl_rstn` out 1: controller reset, active-low.
- `cfg_sel` out 1: selects the internal configuration sequence.
- `cfg_reset` out 1: configuration reset, active-high.
- `cfg_start` out 1: configuration start.
- `axi_arstn` out 1: level fed to per-domain synchronisers for `axi0/axi1_ARESETn` and `regARESETn`.
- `init_done` out 1: high only in RUN.
- `init_err` out 1: high only in HALT.
- `err_code` out 2: last error. 0 none, 1 lock timeout, 2 cfg timeout, 3 lock lost.
- `retry_cnt` out 2: retries consumed.
- `state` out 4: current FSM state code.

## Operation
- All outputs are registered. Synchronisers reset to 0.
- One down-counter is shared by all timed states. Its width is `$clog2` of the largest parameter plus 1. It is loaded on every state entry.
- State codes:
  - IDLE 0: one cycle, then PLL_RST.
  - PLL_RST 1: all resets asserted, `cfg_sel`=1. Stays for PLL_RST_CYC cycles, then PLL_WAIT.
  - PLL_WAIT 2: `ddr_pll_rstn`=1.
    - `lock_s`=1 → PHY_REL.
    - Counter expires → ERR with code 1.
  - PHY_REL 3: `phy_rstn`=1, dwell RST_GAP_CYC, then CTRL_REL.
  - CTRL_REL 4: `ctrl_rstn`=1, dwell RST_GAP_CYC, then CFG.
  - CFG 5: `cfg_reset`=0, `cfg_start`=1.
    - `done_s`=1 → `cfg_start`=0, go to AXI_REL.
    - Counter expires → ERR with code 2.
  - AXI_REL 6: dwell RST_GAP_CYC, then `axi_arstn`=1, go to RUN.
  - RUN 7: `init_done`=1.
  - ERR 8: one cycle. All resets are re-asserted and `cfg_start`=0.
    - If `retry_cnt` < MAX_RETRY: increment `retry_cnt`, go to PLL_RST.
    - Otherwise: go to HALT.
  - HALT 9: all resets asserted, `cfg_sel`=0, `init_err`=1.
- Lock supervision: `lock_s`=0 in any of PHY_REL, CTRL_REL, CFG, AXI_REL or RUN → ERR with code 3.
- `err_code` is written only on ERR entry. It is sticky through a successful retry.
- `start`:
  - In RUN or HALT: clears `retry_cnt`, `err_code`, `init_done` and `init_err`, then goes to PLL_RST.
  - In all other states: ignored.
- Output values by state group:
  - `cfg_reset` = 1 in every state except CFG, AXI_REL and RUN.
  - `cfg_sel` = 1 from PLL_RST through RUN.

## Timing
- Reset values: `ddr_pll_rstn`=0, `phy_rstn`=0, `ctrl_rstn`=0, `axi_arstn`=0, `cfg_reset`=1, `cfg_start`=0, `cfg_sel`=0, `init_done`=0, `init_err`=0, `err_code`=0, `retry_cnt`=0, `state`=0.
- Input sampling latency: 2 cycles (synchroniser) plus 1 cycle (FSM register) from an input edge to the output change.
- Each timed state lasts exactly N cycles for parameter N.
- Event and timeout in the same cycle: the event wins.
- `cfg_start` drops on the cycle after `done_s` is sampled high. It is never re-asserted within one attempt.
- Minimum init with inputs already asserted: 1 + PLL_RST_CYC + 3 (lock sync) + 2·RST_GAP_CYC + 3 (done sync) + RST_GAP_CYC cycles.
- `sys_rstn` low at any time returns all outputs to their reset values asynchronously.

## Configuration
- `DDR_INIT_RETRY_EN` defined: retry behaviour as in Operation.
- `DDR_INIT_RETRY_EN` undefined:
  - ERR always goes to HALT.
  - `retry_cnt` is tied to 0 and MAX_RETRY is ignored.

## Test plan
Bench parameters: PLL_RST_CYC=4, RST_GAP_CYC=2, LOCK_TIMEOUT_CYC=20, CFG_TIMEOUT_CYC=50, MAX_RETRY=2, with `DDR_INIT_RETRY_EN` defined.
- Nominal init: lock asserts 5 cycles after PLL_WAIT entry and `cfg_done` 10 cycles after CFG entry → reset releases in order pll → phy → ctrl → axi. `init_done`=1, `state`=7, `err_code`=0.
- Lock never asserts → three PLL_WAIT timeouts → HALT with `init_err`=1, `err_code`=1, `retry_cnt`=2.
- `cfg_done` absent on the first attempt and present on the second → RUN with `retry_cnt`=1, `err_code`=2.
- Lock drops for 3 cycles in RUN → `init_done`=0 and `axi_arstn`=0 within 4 cycles, `err_code`=3, re-init completes.
- `start` pulse in HALT → `retry_cnt`, `err_code` and `init_err` cleared, PLL_RST entered the next cycle. `start` in CFG is ignored.
- `sys_rstn` asserted mid-CFG → all outputs return to reset values without waiting for a clock edge. After release, the sequence restarts from IDLE.
